// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default widths and the round-robin pick helper
// for the memory port arbiter. No ports.
package mem_arb_pkg;
  localparam int LEN_WIDTH_DEF = 8;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE  = 2'd0;
  localparam arb_state_t ARB_REQ   = 2'd1;
  localparam arb_state_t ARB_RDATA = 2'd2;
  // First set bit of req at or after ptr, wrapping modulo n (n <= 32).
  // Scanning from the far end lets the closest hit overwrite the result last.
  function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
    rr_pick = ptr;
    for (int i = 31; i >= 0; i--)
      if (i < n && req[(ptr + i) % n]) rr_pick = (ptr + i) % n;
  endfunction
endpackage

// File: rtl/mem_port_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick with a registered rotating pointer.
// Ports: clk, reset_n (sync, active-low); req = request vector; advance = a grant is
// being taken this cycle (pointer moves past it); pick = index of the winner.
module rr_arbiter import mem_arb_pkg::*; #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [IW-1:0] pick
);
  logic [IW-1:0] ptr;
  assign pick = IW'(rr_pick(32'(req), int'(ptr), N));
  always_ff @(posedge clk)
    if (!reset_n) ptr <= '0;
    else if (advance) ptr <= (pick == IW'(N - 1)) ? '0 : pick + 1'b1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory request port between NUM_REQ cache controllers
// with round-robin priority, holding the grant for a whole transaction.
// Ports: s_* = requester side (packed per requester; s_rdy/s_valid one-hot to the
// granted requester, s_rdata broadcast); o_mem_*/i_mem_* = memory side;
// o_grant = current/last grant, o_busy = not idle, o_proto_err = sticky protocol error.
module mem_port_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_SIZE_BYTES = 4,
  parameter int LEN_WIDTH       = LEN_WIDTH_DEF,
  parameter int NUM_REQ         = 2,
  parameter int IDX_WIDTH       = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_REQ-1:0]                 s_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      s_addr,
  input  logic [NUM_REQ-1:0]                 s_wen,
  input  logic [NUM_REQ*DATA_SIZE_BYTES-1:0] s_ben,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]       s_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      s_wdata,
  output logic [NUM_REQ-1:0]                 s_rdy,
  output logic [NUM_REQ-1:0]                 s_valid,
  output logic [DATA_WIDTH-1:0]              s_rdata,
  output logic                               o_mem_req,
  output logic [ADDR_WIDTH-1:0]              o_mem_addr,
  output logic                               o_mem_wen,
  output logic [DATA_SIZE_BYTES-1:0]         o_mem_ben,
  output logic [LEN_WIDTH-1:0]               o_mem_len,
  output logic [DATA_WIDTH-1:0]              o_mem_data,
  input  logic                               i_mem_rdy,
  input  logic                               i_mem_valid,
  input  logic [DATA_WIDTH-1:0]              i_mem_data,
  output logic [IDX_WIDTH-1:0]               o_grant,
  output logic                               o_busy,
  output logic                               o_proto_err
);
  arb_state_t                 state;
  logic [IDX_WIDTH-1:0]       pick;
  logic [ADDR_WIDTH-1:0]      addr_q;
  logic                       wen_q;
  logic [DATA_SIZE_BYTES-1:0] ben_q;
  logic [LEN_WIDTH-1:0]       len_q;
  logic [DATA_WIDTH-1:0]      data_q;
  logic [LEN_WIDTH-1:0]       cnt;
  logic [NUM_REQ-1:0]         grant_oh;
  logic                       in_idle, in_req, in_rdata;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_rr (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (s_req),
    .advance (in_idle && |s_req),
    .pick    (pick)
  );

  assign in_idle    = state == ARB_IDLE;
  assign in_req     = state == ARB_REQ;
  assign in_rdata   = state == ARB_RDATA;
  assign grant_oh   = NUM_REQ'(1) << o_grant;
  assign s_rdy      = (in_req && i_mem_rdy) ? grant_oh : '0;
  assign s_valid    = (in_rdata && i_mem_valid) ? grant_oh : '0;
  assign s_rdata    = i_mem_data;
  assign o_mem_req  = in_req;
  assign o_mem_addr = in_req ? addr_q : '0;
  assign o_mem_wen  = in_req && wen_q;
  assign o_mem_ben  = in_req ? ben_q : '0;
  assign o_mem_len  = in_req ? len_q : '0;
  assign o_mem_data = in_req ? data_q : '0;
  assign o_busy     = !in_idle;

  // Stray memory pulses and early withdrawal only raise the flag; the transaction
  // in flight is still carried to completion.
  always_ff @(posedge clk)
    if (!reset_n) begin
      state       <= ARB_IDLE;
      o_grant     <= '0;
      addr_q      <= '0;
      wen_q       <= 1'b0;
      ben_q       <= '0;
      len_q       <= '0;
      data_q      <= '0;
      cnt         <= '0;
      o_proto_err <= 1'b0;
    end else begin
      if ((i_mem_valid && !in_rdata) || (i_mem_rdy && !in_req) || (in_req && !s_req[o_grant]))
        o_proto_err <= 1'b1;
      case (state)
        ARB_IDLE: if (|s_req) begin
          state   <= ARB_REQ;
          o_grant <= pick;
          addr_q  <= s_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wen_q   <= s_wen[pick];
          ben_q   <= s_ben[pick*DATA_SIZE_BYTES +: DATA_SIZE_BYTES];
          len_q   <= s_len[pick*LEN_WIDTH +: LEN_WIDTH];
          data_q  <= s_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
        end
        ARB_REQ: if (i_mem_rdy) begin
          state <= wen_q ? ARB_IDLE : ARB_RDATA;
          cnt   <= len_q;
        end
        ARB_RDATA: if (i_mem_valid) begin
          if (cnt == '0) state <= ARB_IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory request port between NUM_REQ cache controllers (e.g. I-cache line fill and D-cache fill/write-through).
- Uses round-robin priority.
- A grant is held for the whole transaction:
  - reads: request handshake plus len+1 data beats;
  - writes: request handshake only.
- Sits between the cache controllers' o_mem_* ports and the memory/bus bridge. It forwards handshakes and steers the return data.

Parameters:
- ADDR_WIDTH, 10, byte address width
- DATA_WIDTH, 32, data word width
- DATA_SIZE_BYTES, 4, byte enables per word
- LEN_WIDTH, 8, burst length field (beats minus 1)
- NUM_REQ, 2, number of requesters (at least 2)
- IDX_WIDTH, $clog2(NUM_REQ), grant index width

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- s_req  in  NUM_REQ  per-requester request, held until its s_rdy
- s_addr  in  NUM_REQ*ADDR_WIDTH  packed, requester r at [r*ADDR_WIDTH +: ADDR_WIDTH]
- s_wen  in  NUM_REQ  1 = write
- s_ben  in  NUM_REQ*DATA_SIZE_BYTES  write byte enables
- s_len  in  NUM_REQ*LEN_WIDTH  read beats minus 1; ignored for writes
- s_wdata  in  NUM_REQ*DATA_WIDTH  write data
- s_rdy  out  NUM_REQ  one-cycle request-accepted pulse to the granted requester
- s_valid  out  NUM_REQ  read beat valid to the granted requester
- s_rdata  out  DATA_WIDTH  read data, broadcast to all requesters
- o_mem_req  out  1  memory request
- o_mem_addr  out  ADDR_WIDTH
- o_mem_wen  out  1
- o_mem_ben  out  DATA_SIZE_BYTES
- o_mem_len  out  LEN_WIDTH
- o_mem_data  out  DATA_WIDTH
- i_mem_rdy  in  1  memory accepts the request (one-cycle pulse)
- i_mem_valid  in  1  read data beat
- i_mem_data  in  DATA_WIDTH
- o_grant  out  IDX_WIDTH  current or last granted index
- o_busy  out  1  state != IDLE
- o_proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (reset_n low at posedge): state IDLE, rr_ptr 0, beat counter 0, o_grant 0, o_proto_err 0. All outputs 0.
- State IDLE:
  - If any s_req is high, grant the first requester at or after rr_ptr (wrapping modulo NUM_REQ).
  - Register the grant into o_grant and latch the requester's addr/wen/ben/len/wdata.
  - Set rr_ptr = grant+1 mod NUM_REQ.
  - Go to REQ.
  - No s_req high: stay in IDLE.
- State REQ:
  - o_mem_req = 1; o_mem_* driven from the latched registers.
  - Latency: s_req rising in IDLE gives o_mem_req high on the next cycle.
  - On i_mem_rdy: s_rdy[o_grant] = 1 combinationally that cycle, and o_mem_req drops the next cycle.
    - wen=1: go to IDLE.
    - wen=0: load beat counter = len and go to RDATA.
- State RDATA:
  - o_mem_req = 0.
  - s_valid[o_grant] = i_mem_valid (combinational); s_rdata = i_mem_data at all times.
  - On each i_mem_valid: if counter == 0, go to IDLE; else decrement the counter.
  - len=0 means a single beat.
- Back-to-back: after completion there is one IDLE bubble cycle before the next o_mem_req. The same requester cannot win twice in a row while another is requesting.
- o_mem_* outputs other than o_mem_req are zero outside REQ.
- s_rdy and s_valid are never asserted to a non-granted requester, and never both in the same cycle.
- o_proto_err set (sticky until reset) on any of:
  - i_mem_valid outside RDATA;
  - i_mem_rdy outside REQ;
  - s_req[o_grant] low while in REQ (requester withdrew before acceptance).
  - The arbiter otherwise continues normally: stray pulses are ignored; a withdrawn request is still issued to completion.
- Memory contract: the first i_mem_valid comes at least 1 cycle after i_mem_rdy.
- Reset mid-transaction: immediate return to IDLE with all outputs 0 and no completion pulse. The memory side is reset in the same domain.
- Requesters must sample s_rdata only when their own s_valid is high.

Decomposition:
- Shared package mem_arb_pkg:
  - state enum arb_state_t {ARB_IDLE, ARB_REQ, ARB_RDATA};
  - LEN_WIDTH default constant;
  - function rr_pick(req vector, ptr), returning the index.
- One natural sub-module, rr_arbiter: combinational round-robin pick plus registered pointer, reusable elsewhere.
- Handshake properties go in a bound props module, reusing the REQ/RDY/VALID property macros.

Test Plan:
- Single read: s_req[0]=1, addr 0x040, len=3, i_mem_rdy at cycle 3, valid beats cycles 5-8 with data A..D -> o_mem_req high cycles 1-3; s_rdy[0] at cycle 3; s_valid[0] on 4 beats with s_rdata A..D; o_busy low at cycle 9; s_valid[1] never high.
- Contention: s_req=2'b11 from cycle 0, both reads with len=0 -> grant order 0,1,0,1 across four transactions; o_grant matches; one idle cycle between completions.
- Write: requester 1, addr 0x1FC, ben 4'b0011, data 0xDEADBEEF, rdy at cycle 2 -> o_mem_wen=1, o_mem_ben=0011, o_mem_data=0xDEADBEEF; s_rdy[1] at cycle 2; back to IDLE with no data phase.
- Write during read: requester 0 reading len=3, requester 1 raises a write at beat 2 -> write o_mem_req only after the read's last beat plus one bubble.
- Protocol error: i_mem_valid pulse while IDLE -> o_proto_err=1 and stays set; no s_valid asserted; the subsequent normal read completes correctly.
- Reset mid-burst: reset_n low after 2 of 4 beats -> next cycle all outputs 0, state IDLE, o_grant 0; a fresh request after release is granted to requester 0.
